flag_gen: RTL

FLAG_GEN -- requirements
Module: flag_gen

---
 rtl/flag_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/flag_gen.sv
// Two-stage branch-compare flag generator: S1 subtracts the low halves, S2 finishes
// the upper half with the S1 borrow and registers Zero/Negative/Overflow/Carry.
module flag_gen #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            Zero,
  output logic            Negative,
  output logic            Overflow,
  output logic            Carry,
  output logic [2:0]      funct3_out
);

  localparam int H = XLEN / 2;

  logic         r_s1_valid;
  logic [H-1:0] r_s1_dlo;
  logic         r_s1_blo;
  logic         r_s1_zlo;
  logic [H-1:0] r_s1_ahi;
  logic [H-1:0] r_s1_bhi;
  logic [2:0]   r_s1_f3;

  logic         r_s2_valid;
  logic         r_zero;
  logic         r_neg;
  logic         r_ovf;
  logic         r_carry;
  logic [2:0]   r_f3;

  logic [H:0]   w_lo_diff;
  logic [H:0]   w_hi_diff;
  logic         w_s2_xfer;
  logic         w_s2_load;
  logic         w_accept;
  logic         w_zero;

  // Extra top bit of each difference is the borrow-out; the upper half consumes the low borrow.
  assign w_lo_diff = {1'b0, rs1[H-1:0]} - {1'b0, rs2[H-1:0]};
  assign w_hi_diff = {1'b0, r_s1_ahi} - {1'b0, r_s1_bhi} - {{H{1'b0}}, r_s1_blo};
  assign w_zero    = r_s1_zlo & (w_hi_diff[H-1:0] == {H{1'b0}});

  assign w_s2_xfer = r_s2_valid & out_ready;
  assign w_s2_load = r_s1_valid & (~r_s2_valid | w_s2_xfer);
  assign in_ready  = ~r_s1_valid | w_s2_load;
  assign w_accept  = in_valid & in_ready;

  // Stage 1: capture the low-half result and the operands' upper halves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_dlo   <= {H{1'b0}};
      r_s1_blo   <= 1'b0;
      r_s1_zlo   <= 1'b0;
      r_s1_ahi   <= {H{1'b0}};
      r_s1_bhi   <= {H{1'b0}};
      r_s1_f3    <= 3'b000;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_dlo   <= w_lo_diff[H-1:0];
      r_s1_blo   <= w_lo_diff[H];
      r_s1_zlo   <= (rs1[H-1:0] == rs2[H-1:0]);
      r_s1_ahi   <= rs1[XLEN-1:H];
      r_s1_bhi   <= rs2[XLEN-1:H];
      r_s1_f3    <= funct3_in;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: finish the upper half and register the flags the consumer sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
      r_ovf      <= 1'b0;
      r_carry    <= 1'b0;
      r_f3       <= 3'b000;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_zero     <= w_zero;
      r_neg      <= w_hi_diff[H-1];
      r_ovf      <= (r_s1_ahi[H-1] != r_s1_bhi[H-1]) & (w_hi_diff[H-1] != r_s1_ahi[H-1]);
      r_carry    <= w_hi_diff[H];
      r_f3       <= r_s1_f3;
    end else if (w_s2_xfer) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid  = r_s2_valid;
  assign Zero       = r_zero;
  assign Negative   = r_neg;
  assign Overflow   = r_ovf;
  assign Carry      = r_carry;
  assign funct3_out = r_f3;

endmodule
